// File: rtl/demux4_router.sv
// Four-channel demultiplexing router. Each channel has a one-deep holding
// register with valid/ready handshaking, plus an occupancy count and a transfer counter.
module demux4_router #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_sel,
  output logic [N-1:0] out_data0,
  output logic [N-1:0] out_data1,
  output logic [N-1:0] out_data2,
  output logic [N-1:0] out_data3,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [2:0]   occupancy,
  output logic [15:0]  xfer_count
);

  logic [N-1:0] data_q [4];
  logic [3:0]   full_q;
  logic [3:0]   deliver;
  logic [3:0]   load;
  logic [3:0]   full_d;
  logic [2:0]   occ_d;
  logic         accept;

  // A channel can take new data when it is empty or is being drained this
  // same cycle, which gives back-to-back throughput without a bubble.
  always_comb begin
    deliver  = full_q & out_ready;
    in_ready = ~full_q[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
    load     = 4'b0000;
    if (accept) load[in_sel] = 1'b1;
    full_d = (full_q & ~deliver) | load;
    occ_d  = 3'd0;
    for (int k = 0; k < 4; k++) occ_d = occ_d + {2'b00, full_d[k]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q     <= 4'b0000;
      occupancy  <= 3'd0;
      xfer_count <= 16'h0000;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      full_q    <= full_d;
      occupancy <= occ_d;
      if (accept) xfer_count <= xfer_count + 16'h0001;
      for (int k = 0; k < 4; k++) begin
        if (load[k]) data_q[k] <= in_data;
      end
    end
  end

  assign out_valid = full_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

endmodule

// File: tb/tb_demux4_router.sv
// Scoreboard bench for demux4_router: payloads are queued on accept and
// matched against the channel data when that channel delivers.
module tb_demux4_router;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [7:0]  out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [2:0]  occupancy;
  logic [15:0] xfer_count;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [3:0]  mfull;
  logic [7:0]  mdata [4];
  logic [15:0] mcount;
  int          checks;
  int          errors;

  demux4_router #(.N(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_sel(in_sel),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dout(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic [2:0] popcount(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 0; k < 4; k++) c = c + {2'b00, v[k]};
    return c;
  endfunction

  task automatic clearModel();
    mfull  = 4'b0000;
    mcount = 16'h0000;
    for (int k = 0; k < 4; k++) mdata[k] = 8'h00;
    sb.delete();
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_out_valid"}, {28'd0, out_valid}, 32'd0);
    checkOutput({tag, "_occupancy"}, {29'd0, occupancy}, 32'd0);
    checkOutput({tag, "_xfer_count"}, {16'd0, xfer_count}, 32'd0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("%s_out_data%0d", tag, k), {24'd0, dout(k)}, 32'd0);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 8'h00;
    out_ready = 4'b0000;
    #1;
    checkCleared("reset_async");
    @(posedge clk);
    #1;
    checkCleared("reset_edge");
    reset = 1'b0;
    clearModel();
  endtask

  // Drives one cycle, predicts in_ready and deliveries, then compares state after the edge.
  task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [7:0] data,
                               input logic [3:0] ordy);
    logic       exp_ready;
    logic [3:0] dlv;
    logic       found;
    int         idx;
    in_valid  = v;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
    #2;
    exp_ready = 1'b0;
    if (!$isunknown(sel)) begin
      exp_ready = !mfull[sel] || ordy[sel];
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    end
    dlv = mfull & ordy;
    for (int k = 0; k < 4; k++) begin
      if (dlv[k]) begin
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < sb.size(); i++) begin
          if (!found && sb[i].sel == 2'(k)) begin
            found = 1'b1;
            idx   = i;
          end
        end
        checkOutput($sformatf("sb_hit%0d", k), {31'd0, found}, 32'd1);
        if (found) begin
          checkOutput($sformatf("deliver_data%0d", k), {24'd0, dout(k)}, {24'd0, sb[idx].data});
          sb.delete(idx);
        end
        mfull[k] = 1'b0;
      end
    end
    if (v && exp_ready) begin
      sb.push_back('{sel: sel, data: data});
      mfull[sel] = 1'b1;
      mdata[sel] = data;
      mcount     = mcount + 16'h0001;
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", {28'd0, out_valid}, {28'd0, mfull});
    checkOutput("occupancy", {29'd0, occupancy}, {29'd0, popcount(mfull)});
    checkOutput("xfer_count", {16'd0, xfer_count}, {16'd0, mcount});
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("out_data%0d", k), {24'd0, dout(k)}, {24'd0, mdata[k]});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearModel();
    doReset();

    // First request after reset, then stall, then same-cycle replace.
    applyStimulus(1'b1, 2'd2, 8'hA5, 4'b0000);
    applyStimulus(1'b1, 2'd2, 8'h3C, 4'b0000);
    applyStimulus(1'b1, 2'd2, 8'h3C, 4'b0100);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

    // Fill all channels, drain together, data retained.
    applyStimulus(1'b1, 2'd0, 8'h11, 4'b0000);
    applyStimulus(1'b1, 2'd1, 8'h22, 4'b0000);
    applyStimulus(1'b1, 2'd2, 8'h33, 4'b0000);
    applyStimulus(1'b1, 2'd3, 8'h44, 4'b0000);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
    applyStimulus(1'b0, 2'd1, 8'h00, 4'b0000);

    // Independent channels: accept on one while another drains.
    applyStimulus(1'b1, 2'd0, 8'h5A, 4'b0000);
    applyStimulus(1'b1, 2'd1, 8'h6B, 4'b0000);
    applyStimulus(1'b1, 2'd3, 8'h7C, 4'b0001);
    applyStimulus(1'b1, 2'd1, 8'h8D, 4'b0000);

    // Unknown select with no request must leave everything untouched.
    applyStimulus(1'b0, 2'bxx, 8'hFF, 4'b0000);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));

    // Asynchronous reset between edges with three channels held.
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
    applyStimulus(1'b1, 2'd0, 8'hC1, 4'b0000);
    applyStimulus(1'b1, 2'd1, 8'hC2, 4'b0000);
    applyStimulus(1'b1, 2'd3, 8'hC3, 4'b0000);
    checkOutput("pre_reset_occupancy", {29'd0, occupancy}, 32'd3);
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 8'hEE;
    out_ready = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    checkCleared("midop_reset");
    @(posedge clk);
    #1;
    checkCleared("midop_reset_edge");
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    reset     = 1'b0;
    clearModel();

    // Counter wrap: 65535 accepts reach 0xFFFF, one more wraps to zero.
    for (int i = 0; i < 65535; i++)
      applyStimulus(1'b1, 2'(i % 4), 8'(i), 4'b1111);
    checkOutput("xfer_ffff", {16'd0, xfer_count}, 32'h0000FFFF);
    applyStimulus(1'b1, 2'd0, 8'h99, 4'b1111);
    checkOutput("xfer_wrap", {16'd0, xfer_count}, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
